wb_burst_master: RTL and testbench

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master_if.sv | 49 ++++
 rtl/wb_burst_master.sv | 154 +++++++++++++++
 tb/tb_wb_burst_master.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_if.sv
// Command, write-data, read-data, status and Wishbone B4 signals around wb_burst_master.
// master is the burst engine's view; slave is the command source / Wishbone slave side.
interface wb_burst_master_if #(
  parameter int APP_AW = 26,
  parameter int DW     = 32,
  parameter int BL_W   = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [APP_AW-1:0] cmd_addr;
  logic [BL_W-1:0]   cmd_len;
  logic [DW/8-1:0]   cmd_sel;

  logic              wr_valid;
  logic              wr_ready;
  logic [DW-1:0]     wr_data;

  logic              rd_valid;
  logic              rd_last;
  logic [DW-1:0]     rd_data;

  logic              busy;
  logic              done;
  logic              err;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [DW/8-1:0]   wb_sel_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [DW-1:0]     wb_dat_o;
  logic [2:0]        wb_cti_o;
  logic [1:0]        wb_bte_o;
  logic [DW-1:0]     wb_dat_i;
  logic              wb_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_sel, wr_valid, wr_data, wb_dat_i, wb_ack_i,
    output cmd_ready, wr_ready, rd_valid, rd_last, rd_data, busy, done, err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o, wb_cti_o, wb_bte_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_sel, wr_valid, wr_data, wb_dat_i, wb_ack_i,
    input  cmd_ready, wr_ready, rd_valid, rd_last, rd_data, busy, done, err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o, wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst master: bus cycle starts the edge after command accept, reads
// return in the ack cycle (no backpressure), writes stall in WFETCH until wr_valid; ack timeout aborts.
module wb_burst_master #(
  parameter int APP_AW = 26,
  parameter int DW     = 32,
  parameter int BL_W   = 4,
  parameter int TMO    = 255
) (
  input  logic              wb_clk,
  input  logic              wb_resetn,
  wb_burst_master_if.master bus
);
  localparam int SW = DW / 8;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, WFETCH, BUS, TERM} state_e;

  state_e            state_q;
  logic              cmd_ready_q;
  logic              we_q;
  logic              cyc_q;
  logic              stb_q;
  logic              done_q;
  logic              err_q;
  logic [APP_AW-1:0] addr_q;
  logic [BL_W-1:0]   len_q;
  logic [BL_W-1:0]   beat_q;
  logic [SW-1:0]     sel_q;
  logic [DW-1:0]     dat_q;
  logic [2:0]        cti_q;
  logic [TW-1:0]     tmo_q;

  logic              accept;
  logic              ack;
  logic              last_beat;
  logic [BL_W-1:0]   beat_nxt;

  assign accept    = bus.cmd_valid & cmd_ready_q;
  assign ack       = (state_q == BUS) & stb_q & bus.wb_ack_i;
  assign last_beat = (beat_q == len_q);
  assign beat_nxt  = beat_q + 1'b1;

  function automatic logic [2:0] cti_for(input logic [BL_W-1:0] beat, input logic [BL_W-1:0] len);
    if (len == '0)
      return 3'b000;
    else if (beat == len)
      return 3'b111;
    else
      return 3'b010;
  endfunction

  always_ff @(posedge wb_clk or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      cti_q       <= 3'b000;
      tmo_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q   <= bus.cmd_we;
            addr_q <= bus.cmd_addr;
            len_q  <= bus.cmd_len;
            sel_q  <= bus.cmd_sel;
            beat_q <= '0;
            tmo_q  <= '0;
            cti_q  <= cti_for('0, bus.cmd_len);
            if (bus.cmd_we) begin
              state_q <= WFETCH;
            end else begin
              state_q <= BUS;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        WFETCH: begin
          if (bus.wr_valid) begin
            dat_q   <= bus.wr_data;
            state_q <= BUS;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            tmo_q   <= '0;
          end
        end
        BUS: begin
          if (ack) begin
            tmo_q <= '0;
            if (last_beat) begin
              state_q <= TERM;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Address only advances toward a following beat, so it parks on the last beat's address.
              beat_q <= beat_nxt;
              addr_q <= addr_q + APP_AW'(SW);
              cti_q  <= cti_for(beat_nxt, len_q);
              if (we_q) begin
                state_q <= WFETCH;
                stb_q   <= 1'b0;
              end
            end
          end else if (tmo_q == TW'(TMO - 1)) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        TERM: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = (state_q == WFETCH);
  assign bus.rd_valid  = ack & ~we_q;
  assign bus.rd_last   = ack & ~we_q & last_beat;
  assign bus.rd_data   = (ack & ~we_q) ? bus.wb_dat_i : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = stb_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_sel_o  = sel_q;
  assign bus.wb_addr_o = addr_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.wb_cti_o  = cti_q;
  assign bus.wb_bte_o  = 2'b00;
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: command table plus hand-written timeout, reset and 64-bit bursts,
// with per-beat expectations queued at issue time and checked on every ack.
module tb_wb_burst_master;
  localparam logic [31:0] WBASE = 32'hD000_0000;

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [3:0]  len;
    logic [3:0]  sel;
    int          dly;
    bit          stray;
    logic [25:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [25:0] addr;
    logic [2:0]  cti;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        last;
  } beat_t;

  logic  wb_clk = 1'b0;
  logic  wb_resetn;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    wr_idx = 0;
  int    ack_dly = 0;
  bit    ack_en = 1'b1;
  bit    stray_en = 1'b0;
  int    beats_acked = 0;
  int    acks64 = 0;
  int    last64 = 0;
  beat_t sb[$];
  beat_t sb64[$];

  always #5 wb_clk = ~wb_clk;

  wb_burst_master_if #(.APP_AW(26), .DW(32), .BL_W(4)) b ();
  wb_burst_master_if #(.APP_AW(26), .DW(64), .BL_W(4)) b64 ();

  wb_burst_master #(.APP_AW(26), .DW(32), .BL_W(4), .TMO(255)) dut (
    .wb_clk(wb_clk), .wb_resetn(wb_resetn), .bus(b));
  wb_burst_master #(.APP_AW(26), .DW(64), .BL_W(4), .TMO(255)) dut64 (
    .wb_clk(wb_clk), .wb_resetn(wb_resetn), .bus(b64));

  function automatic logic [31:0] rmodel32(input logic [25:0] a);
    return 32'hA500_0000 ^ {6'd0, a};
  endfunction

  function automatic logic [63:0] rmodel64(input logic [25:0] a);
    return {32'h0BAD_F00D, 6'd0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Wishbone slave model for the 32-bit instance; checks each acked beat against the queue.
  initial begin
    int    wait_cnt;
    beat_t e;
    wait_cnt = 0;
    b.wb_ack_i = 1'b0;
    b.wb_dat_i = '0;
    forever begin
      @(negedge wb_clk);
      if (b.wb_stb_o && !b.wb_ack_i && ack_en) begin
        if (wait_cnt >= ack_dly) begin
          b.wb_ack_i = 1'b1;
          b.wb_dat_i = rmodel32(b.wb_addr_o);
          wait_cnt = 0;
          beats_acked++;
          #1;
          if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_beat: got beat at addr %0h, expected none", b.wb_addr_o);
          end else begin
            e = sb.pop_front();
            chk("beat_addr", 64'(b.wb_addr_o), 64'(e.addr));
            chk("beat_cti", 64'(b.wb_cti_o), 64'(e.cti));
            chk("beat_we", 64'(b.wb_we_o), 64'(e.we));
            chk("beat_sel", 64'(b.wb_sel_o), 64'(e.sel));
            chk("beat_cyc", 64'(b.wb_cyc_o), 64'(1));
            chk("beat_bte", 64'(b.wb_bte_o), 64'(0));
            if (e.we) begin
              chk("wr_dat", 64'(b.wb_dat_o), 64'(e.dat));
              chk("rd_valid_on_wr", 64'(b.rd_valid), 64'(0));
            end else begin
              chk("rd_valid", 64'(b.rd_valid), 64'(1));
              chk("rd_last", 64'(b.rd_last), 64'(e.last));
              chk("rd_data", 64'(b.rd_data), 64'(rmodel32(e.addr)));
            end
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        b.wb_ack_i = stray_en && b.wr_ready && !b.wb_ack_i;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    beat_t e;
    b64.wb_ack_i = 1'b0;
    b64.wb_dat_i = '0;
    forever begin
      @(negedge wb_clk);
      if (b64.wb_stb_o && !b64.wb_ack_i) begin
        b64.wb_ack_i = 1'b1;
        b64.wb_dat_i = rmodel64(b64.wb_addr_o);
        acks64++;
        #1;
        if (b64.rd_last) last64++;
        if (sb64.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_beat64: got beat at addr %0h, expected none", b64.wb_addr_o);
        end else begin
          e = sb64.pop_front();
          chk("b64_addr", 64'(b64.wb_addr_o), 64'(e.addr));
          chk("b64_rd_valid", 64'(b64.rd_valid), 64'(1));
          chk("b64_rd_last", 64'(b64.rd_last), 64'(e.last));
          chk("b64_rd_data", b64.rd_data, rmodel64(e.addr));
        end
      end else begin
        b64.wb_ack_i = 1'b0;
      end
    end
  end

  // Write-data source with random stalls; wr_idx counts completed handshakes.
  initial begin
    logic rdy_seen;
    rdy_seen = 1'b0;
    b.wr_valid = 1'b0;
    b.wr_data = '0;
    forever begin
      @(negedge wb_clk);
      if (b.wr_valid && rdy_seen) wr_idx++;
      b.wr_valid = ($urandom_range(0, 2) != 0);
      b.wr_data = WBASE + 32'(wr_idx);
      rdy_seen = b.wr_ready;
    end
  end

  task automatic issue(input vec_t v);
    logic [31:0] base;
    beat_t       e;
    base = WBASE + 32'(wr_idx);
    beats_acked = 0;
    ack_dly = v.dly;
    stray_en = v.stray;
    for (int i = 0; i <= int'(v.len); i++) begin
      e.addr = v.addr + 26'(i * 4);
      e.cti  = (v.len == 4'd0) ? 3'b000 : ((i == int'(v.len)) ? 3'b111 : 3'b010);
      e.we   = v.we;
      e.sel  = v.sel;
      e.dat  = base + 32'(i);
      e.last = (i == int'(v.len));
      sb.push_back(e);
    end
    @(negedge wb_clk);
    chk("cmd_ready_idle", 64'(b.cmd_ready), 64'(1));
    b.cmd_valid = 1'b1;
    b.cmd_we = v.we;
    b.cmd_addr = v.addr;
    b.cmd_len = v.len;
    b.cmd_sel = v.sel;
    @(negedge wb_clk);
    #1;
    b.cmd_valid = 1'b0;
    chk("busy_after_accept", 64'(b.busy), 64'(1));
    chk("cmd_ready_busy", 64'(b.cmd_ready), 64'(0));
  endtask

  task automatic run_cmd(input vec_t v);
    int cyc;
    issue(v);
    cyc = 0;
    while (!b.done && !b.err && cyc < 2000) begin
      if (b.wr_ready) begin
        chk("wfetch_stb", 64'(b.wb_stb_o), 64'(0));
        chk("wfetch_cyc", 64'(b.wb_cyc_o), 64'(beats_acked > 0));
      end
      @(negedge wb_clk);
      #1;
      cyc++;
    end
    chk("done_seen", 64'(b.done), 64'(1));
    chk("err_quiet", 64'(b.err), 64'(0));
    chk("term_cyc", 64'(b.wb_cyc_o), 64'(0));
    chk("term_stb", 64'(b.wb_stb_o), 64'(0));
    chk("term_rdy", 64'(b.cmd_ready), 64'(0));
    chk("final_addr", 64'(b.wb_addr_o), 64'(v.exp_addr));
    chk("sb_drained", 64'(sb.size()), 64'(0));
    @(negedge wb_clk);
    #1;
    chk("done_single", 64'(b.done), 64'(0));
    chk("rdy_after_term", 64'(b.cmd_ready), 64'(1));
    chk("idle_busy", 64'(b.busy), 64'(0));
  endtask

  initial begin
    vec_t  vt[6];
    vec_t  rv;
    beat_t e;
    int    n;
    int    dn;

    vt[0] = '{we:1'b0, addr:26'h100,     len:4'd0,  sel:4'hF, dly:2, stray:1'b0, exp_addr:26'h100};
    vt[1] = '{we:1'b1, addr:26'h200,     len:4'd3,  sel:4'hF, dly:1, stray:1'b0, exp_addr:26'h20C};
    vt[2] = '{we:1'b0, addr:26'h3FFFFFC, len:4'd1,  sel:4'h3, dly:0, stray:1'b0, exp_addr:26'h0};
    vt[3] = '{we:1'b1, addr:26'h40,      len:4'd0,  sel:4'h1, dly:0, stray:1'b0, exp_addr:26'h40};
    vt[4] = '{we:1'b0, addr:26'h1000,    len:4'd15, sel:4'hC, dly:1, stray:1'b0, exp_addr:26'h103C};
    vt[5] = '{we:1'b1, addr:26'h3FFFFF8, len:4'd2,  sel:4'hF, dly:3, stray:1'b1, exp_addr:26'h0};

    wb_resetn = 1'b0;
    b.cmd_valid = 1'b0; b.cmd_we = 1'b0; b.cmd_addr = '0; b.cmd_len = '0; b.cmd_sel = '0;
    b64.cmd_valid = 1'b0; b64.cmd_we = 1'b0; b64.cmd_addr = '0; b64.cmd_len = '0; b64.cmd_sel = '0;
    b64.wr_valid = 1'b0; b64.wr_data = '0;

    repeat (3) @(negedge wb_clk);
    #1;
    chk("rst_cmd_ready", 64'(b.cmd_ready), 64'(0));
    chk("rst_busy", 64'(b.busy), 64'(0));
    chk("rst_cyc", 64'(b.wb_cyc_o), 64'(0));
    chk("rst_stb", 64'(b.wb_stb_o), 64'(0));
    chk("rst_addr", 64'(b.wb_addr_o), 64'(0));
    chk("rst_cti", 64'(b.wb_cti_o), 64'(0));
    chk("rst_wr_ready", 64'(b.wr_ready), 64'(0));
    chk("rst_done_err", 64'({b.done, b.err}), 64'(0));
    chk("rst64_cyc", 64'(b64.wb_cyc_o), 64'(0));
    #1 wb_resetn = 1'b1;
    #1 chk("rdy_before_edge", 64'(b.cmd_ready), 64'(0));
    @(negedge wb_clk);
    #1 chk("rdy_first_cycle", 64'(b.cmd_ready), 64'(1));

    for (int i = 0; i < 6; i++) run_cmd(vt[i]);
    stray_en = 1'b0;

    // Ack timeout: slave never answers a 3-beat read.
    ack_en = 1'b0;
    rv = '{we:1'b0, addr:26'h500, len:4'd2, sel:4'hF, dly:0, stray:1'b0, exp_addr:26'h500};
    issue(rv);
    n = 0;
    dn = 0;
    while (b.wb_stb_o && n < 400) begin
      n++;
      if (b.done) dn++;
      @(negedge wb_clk);
      #1;
    end
    chk("tmo_stb_cycles", 64'(n), 64'(255));
    chk("tmo_err", 64'(b.err), 64'(1));
    chk("tmo_done", 64'(b.done), 64'(0));
    chk("tmo_cyc", 64'(b.wb_cyc_o), 64'(0));
    chk("tmo_no_done", 64'(dn), 64'(0));
    @(negedge wb_clk);
    #1;
    chk("tmo_rdy_next", 64'(b.cmd_ready), 64'(1));
    chk("tmo_err_pulse", 64'(b.err), 64'(0));
    sb.delete();
    ack_en = 1'b1;

    // Reset asserted while beat 2 of an 8-beat write is on the bus.
    rv = '{we:1'b1, addr:26'h800, len:4'd7, sel:4'hF, dly:3, stray:1'b0, exp_addr:26'h800};
    issue(rv);
    n = 0;
    while (!(beats_acked == 1 && b.wb_stb_o && !b.wb_ack_i) && n < 200) begin
      @(negedge wb_clk);
      #1;
      n++;
    end
    chk("rst_at_beat2", 64'(beats_acked), 64'(1));
    #1 wb_resetn = 1'b0;
    #1;
    chk("mid_rst_cyc", 64'(b.wb_cyc_o), 64'(0));
    chk("mid_rst_stb", 64'(b.wb_stb_o), 64'(0));
    chk("mid_rst_busy", 64'(b.busy), 64'(0));
    chk("mid_rst_rdy", 64'(b.cmd_ready), 64'(0));
    chk("mid_rst_wr_ready", 64'(b.wr_ready), 64'(0));
    sb.delete();
    repeat (3) @(negedge wb_clk);
    #2 wb_resetn = 1'b1;
    #1 chk("rel_rdy_before_edge", 64'(b.cmd_ready), 64'(0));
    @(negedge wb_clk);
    #1 chk("rel_rdy_first_cycle", 64'(b.cmd_ready), 64'(1));
    rv = '{we:1'b0, addr:26'h40, len:4'd1, sel:4'hF, dly:0, stray:1'b0, exp_addr:26'h44};
    run_cmd(rv);

    // 16-beat read on the 64-bit instance.
    acks64 = 0;
    last64 = 0;
    for (int i = 0; i < 16; i++) begin
      e.addr = 26'h2000 + 26'(i * 8);
      e.cti = 3'b000; e.we = 1'b0; e.sel = 4'h0; e.dat = '0;
      e.last = (i == 15);
      sb64.push_back(e);
    end
    @(negedge wb_clk);
    b64.cmd_valid = 1'b1;
    b64.cmd_addr = 26'h2000;
    b64.cmd_len = 4'd15;
    b64.cmd_sel = 8'hFF;
    @(negedge wb_clk);
    #1;
    b64.cmd_valid = 1'b0;
    n = 0;
    while (!b64.done && n < 500) begin
      @(negedge wb_clk);
      #1;
      n++;
    end
    chk("b64_done", 64'(b64.done), 64'(1));
    chk("b64_err", 64'(b64.err), 64'(0));
    chk("b64_acks", 64'(acks64), 64'(16));
    chk("b64_last_count", 64'(last64), 64'(1));
    chk("b64_sb_drained", 64'(sb64.size()), 64'(0));
    chk("b64_final_addr", 64'(b64.wb_addr_o), 64'(26'h2078));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
